branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Fetch-stage dynamic branch predictor. Pairs with the EX-stage branch unit: this block predicts
//  direction and target at fetch, and the branch unit's resolved outcome trains it. A BHT of 2-bit
//  saturating counters gives direction; a direct-mapped BTB gives the target. Also flags EX-stage
//  mispredicts and supplies the redirect PC, and keeps branch/mispredict statistics.
// PARAMETERS
//  BHT_ENTRIES  64  BHT counters; power of 2; IW = log2(BHT_ENTRIES)
//  BTB_ENTRIES  16  BTB entries; power of 2; BW = log2(BTB_ENTRIES)
//  GHR_BITS     6   global history length (used only with BP_GSHARE_EN); must be <= IW
// PORTS
//  clk            in   1   clock
//  reset_n        in   1   synchronous reset, active-low
//  PCF            in   32  fetch PC
//  predTakenF     out  1   predicted taken
//  predTargetF    out  32  predicted target (BTB target on hit, else PCF+4)
//  predIdxF       out  IW  BHT index used for this lookup; piped to EX as predIdxE
//  branchE        in   1   valid conditional branch in EX (already qualified by stall/flush)
//  jumpE          in   1   valid jal/jalr in EX (always taken)
//  branchTakenE   in   1   resolved direction from branch unit (ignored when jumpE)
//  PCE            in   32  PC of EX instruction
//  PCPlus4E       in   32  PCE+4
//  PCTargetE      in   32  resolved target
//  predTakenE     in   1   predTakenF piped to EX
//  predTargetE    in   32  predTargetF piped to EX
//  predIdxE       in   IW  predIdxF piped to EX
//  mispredictE    out  1   flush/redirect request
//  redirectPCE    out  32  correct next PC
//  statBranches   out  32  resolved branch+jump count
//  statMispred    out  32  mispredict count
// BEHAVIOUR
//  - Lookup combinational from PCF. BTB idx = PCF[BW+1:2], tag = PCF[31:BW+2].
//    btbHit = valid && tag match. predTakenF = btbHit && (entry.isJump || bht[predIdxF][1]).
//    predTargetF = predTakenF ? entry.target : PCF+4.
//  - predIdxF = PCF[IW+1:2] (without BP_GSHARE_EN).
//  - Update when resolve = branchE|jumpE, at the rising edge in the same cycle:
//    taken = jumpE | branchTakenE.
//    branchE: bht[predIdxE] incremented if taken, else decremented; saturates at 2'b11 and 2'b00.
//    jumpE never touches the BHT.
//    If taken: BTB[PCE idx] <= {valid=1, tag, isJump=jumpE, target=PCTargetE} (overwrite on conflict).
//    Not taken: BTB unchanged.
//  - branchE and jumpE both high is illegal; jumpE takes priority.
//  - mispredictE (combinational) = resolve && ((taken != predTakenE) || (taken && predTargetE != PCTargetE)).
//    redirectPCE = taken ? PCTargetE : PCPlus4E. Both outputs are 0 when !resolve.
//  - Stats: statBranches += 1 on each resolve; statMispred += 1 on each mispredictE. Both are 32-bit
//    wrapping counters.
//  - Same-cycle lookup/update to the same entry: the lookup sees the pre-update value
//    (read-before-write).
//  - Reset (sync, any time, including mid-update; reset wins):
//    all BHT counters <= 2'b01 (weakly not-taken); all BTB valid <= 0; stats <= 0; GHR <= 0.
//    BTB tag/target storage is not reset.
//    Outputs after reset: predTakenF=0, predTargetF=PCF+4, mispredictE=0 unless resolve is asserted.
// CONFIGURATION
//  BP_GSHARE_EN defined:
//    predIdxF = PCF[IW+1:2] ^ {{(IW-GHR_BITS){1'b0}}, ghr}.
//    ghr <= {ghr[GHR_BITS-2:0], branchTakenE} on each branchE; jumps do not shift it.
//  BP_GSHARE_EN undefined: no GHR flops; bimodal indexing only.
//  In both modes, updates use the piped predIdxE, never a recomputed index.
// STRUCTURE
//  - bp_pkg:
//    typedef enum logic [1:0] {SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11} bht_ctr_t;
//    typedef struct packed {valid, isJump, tag, target} btb_entry_t;
//    sat_inc/sat_dec functions; reset value constant BHT_RESET = WNT.
//  - One sub-module: bp_btb (BTB array with combinational read/hit and synchronous write/valid clear).
//    BHT, GHR, mispredict logic and stats stay in the top.
// TESTING
//  1 Reset, then PCF=0x100 -> predTakenF=0, predTargetF=0x104, predIdxF=0x00 (bimodal), stats=0.
//  2 Resolve beq at PCE=0x100 taken to 0x80 with predTakenE=0 -> mispredictE=1, redirectPCE=0x80;
//    next cycle PCF=0x100 -> predTakenF=1 (ctr 01->10), predTargetF=0x80.
//  3 Four more not-taken resolves of 0x100 -> ctr saturates at 00; a further not-taken leaves 00;
//    predTakenF=0; BTB entry remains valid.
//  4 jal at PCE=0x200 to 0x400 -> BTB isJump=1; PCF=0x200 predicts taken to 0x400 irrespective of BHT.
//    Alias PCE=0x240 (BTB_ENTRIES=16) taken to 0x500 overwrites the entry -> PCF=0x200 misses.
//  5 Lookup and update of the same entry in one cycle -> lookup returns the old value.
//    reset_n low during a resolve -> tables and stats cleared, no update applied.
//  6 BP_GSHARE_EN: after branches T,T,N, ghr=3'b110 in low bits; PCF=0x100 -> predIdxF=0x00^0x06=0x06.
//    statMispred matches the scoreboard over 1000 random branches.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and counter helpers for the fetch-stage branch predictor.
// Build option BP_GSHARE_EN (see branch_predictor) does not affect this package.
package bp_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bht_ctr_t;

   localparam bht_ctr_t BHT_RESET = WNT;

   // Tag field sized for the smallest BTB; narrower tags are zero-extended.
   localparam int TAG_MAX = 30;

   typedef struct packed {
      logic               valid;
      logic               isJump;
      logic [TAG_MAX-1:0] tag;
      logic [31:0]        target;
   } btb_entry_t;

   function automatic bht_ctr_t sat_inc(input bht_ctr_t c);
      case (c)
         SNT:     return WNT;
         WNT:     return WT;
         WT:      return ST;
         default: return ST;
      endcase
   endfunction

   function automatic bht_ctr_t sat_dec(input bht_ctr_t c);
      case (c)
         ST:      return WT;
         WT:      return WNT;
         WNT:     return SNT;
         default: return SNT;
      endcase
   endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: combinational lookup, synchronous write,
// synchronous clear of valid bits only (tag/target storage is never reset).
module bp_btb
   import bp_pkg::*;
#(
   parameter int ENTRIES = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] rd_pc,
   output logic        rd_hit,
   output logic        rd_is_jump,
   output logic [31:0] rd_target,
   input  logic        wr_en,
   input  logic [31:0] wr_pc,
   input  logic        wr_is_jump,
   input  logic [31:0] wr_target
);

   localparam int BW = $clog2(ENTRIES);

   btb_entry_t         mem [ENTRIES];
   btb_entry_t         rd_entry;
   logic [BW-1:0]      rd_idx;
   logic [BW-1:0]      wr_idx;
   logic [TAG_MAX-1:0] rd_tag;
   logic [TAG_MAX-1:0] wr_tag;
   logic               unused_low_bits;

   assign rd_idx = rd_pc[BW+1:2];
   assign wr_idx = wr_pc[BW+1:2];
   assign rd_tag = TAG_MAX'(rd_pc[31:BW+2]);
   assign wr_tag = TAG_MAX'(wr_pc[31:BW+2]);
   assign unused_low_bits = ^{rd_pc[1:0], wr_pc[1:0]};

   assign rd_entry   = mem[rd_idx];
   assign rd_hit     = rd_entry.valid && (rd_entry.tag == rd_tag);
   assign rd_is_jump = rd_entry.isJump;
   assign rd_target  = rd_entry.target;

   // Reset clears valid bits only; a write overwrites whatever occupies the slot.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            mem[i].valid <= 1'b0;
         end
      end else if (wr_en) begin
         mem[wr_idx] <= '{valid: 1'b1, isJump: wr_is_jump, tag: wr_tag, target: wr_target};
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage bimodal branch predictor (BHT + BTB) with EX-stage mispredict detection and stats.
// Define BP_GSHARE_EN to XOR a global history register into the BHT index.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int BHT_ENTRIES = 64,
   parameter int BTB_ENTRIES = 16,
   parameter int GHR_BITS    = 6
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [31:0]                    PCF,
   output logic                           predTakenF,
   output logic [31:0]                    predTargetF,
   output logic [$clog2(BHT_ENTRIES)-1:0] predIdxF,
   input  logic                           branchE,
   input  logic                           jumpE,
   input  logic                           branchTakenE,
   input  logic [31:0]                    PCE,
   input  logic [31:0]                    PCPlus4E,
   input  logic [31:0]                    PCTargetE,
   input  logic                           predTakenE,
   input  logic [31:0]                    predTargetE,
   input  logic [$clog2(BHT_ENTRIES)-1:0] predIdxE,
   output logic                           mispredictE,
   output logic [31:0]                    redirectPCE,
   output logic [31:0]                    statBranches,
   output logic [31:0]                    statMispred
);

   localparam int IW = $clog2(BHT_ENTRIES);

   bht_ctr_t      bht [BHT_ENTRIES];
   bht_ctr_t      bht_rd;
   logic [IW-1:0] pc_idx;
   logic          resolve;
   logic          taken;
   logic          cond_branch;
   logic          btb_hit;
   logic          btb_is_jump;
   logic [31:0]   btb_target;

   assign pc_idx = PCF[IW+1:2];

`ifdef BP_GSHARE_EN
   logic [GHR_BITS-1:0] ghr;

   assign predIdxF = pc_idx ^ IW'(ghr);

   // History shifts on conditional branches only; jumps leave it alone.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ghr <= '0;
      end else if (cond_branch) begin
         ghr <= {ghr[GHR_BITS-2:0], branchTakenE};
      end
   end
`else
   assign predIdxF = pc_idx;
`endif

   // jumpE overrides a simultaneous branchE, so the BHT only sees true conditional branches.
   assign resolve     = branchE | jumpE;
   assign taken       = jumpE | branchTakenE;
   assign cond_branch = branchE & ~jumpE;

   bp_btb #(
      .ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .clk        (clk),
      .reset_n    (reset_n),
      .rd_pc      (PCF),
      .rd_hit     (btb_hit),
      .rd_is_jump (btb_is_jump),
      .rd_target  (btb_target),
      .wr_en      (resolve & taken),
      .wr_pc      (PCE),
      .wr_is_jump (jumpE),
      .wr_target  (PCTargetE)
   );

   assign bht_rd      = bht[predIdxF];
   assign predTakenF  = btb_hit && (btb_is_jump || bht_rd[1]);
   assign predTargetF = predTakenF ? btb_target : (PCF + 32'd4);

   assign mispredictE = resolve && ((taken != predTakenE) || (taken && (predTargetE != PCTargetE)));
   assign redirectPCE = resolve ? (taken ? PCTargetE : PCPlus4E) : 32'd0;

   // Training uses the index piped from fetch, never one recomputed in EX.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht[i] <= BHT_RESET;
         end
      end else if (cond_branch) begin
         bht[predIdxE] <= branchTakenE ? sat_inc(bht[predIdxE]) : sat_dec(bht[predIdxE]);
      end
   end

   // Wrapping resolve and mispredict counters.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         statBranches <= 32'd0;
         statMispred  <= 32'd0;
      end else begin
         if (resolve) begin
            statBranches <= statBranches + 32'd1;
         end
         if (mispredictE) begin
            statMispred <= statMispred + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed cases plus random traffic against
// an array-based reference model. Follows BP_GSHARE_EN when the macro is defined.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] PCF;
   logic        predTakenF;
   logic [31:0] predTargetF;
   logic [5:0]  predIdxF;
   logic        branchE, jumpE, branchTakenE;
   logic [31:0] PCE, PCPlus4E, PCTargetE;
   logic        predTakenE;
   logic [31:0] predTargetE;
   logic [5:0]  predIdxE;
   logic        mispredictE;
   logic [31:0] redirectPCE, statBranches, statMispred;

   int tests = 0;
   int fails = 0;

   // Reference model state
   int          bht_m [64];
   bit          btb_v [16];
   bit          btb_j [16];
   logic [31:0] btb_pc [16];
   logic [31:0] btb_tgt [16];
   int unsigned ghr_m;
   logic [31:0] n_br, n_mis;

   always #5 clk = ~clk;

   branch_predictor dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .PCF          (PCF),
      .predTakenF   (predTakenF),
      .predTargetF  (predTargetF),
      .predIdxF     (predIdxF),
      .branchE      (branchE),
      .jumpE        (jumpE),
      .branchTakenE (branchTakenE),
      .PCE          (PCE),
      .PCPlus4E     (PCPlus4E),
      .PCTargetE    (PCTargetE),
      .predTakenE   (predTakenE),
      .predTargetE  (predTargetE),
      .predIdxE     (predIdxE),
      .mispredictE  (mispredictE),
      .redirectPCE  (redirectPCE),
      .statBranches (statBranches),
      .statMispred  (statMispred)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic int m_idx(input logic [31:0] pc);
`ifdef BP_GSHARE_EN
      return int'(((pc >> 2) ^ ghr_m) % 64);
`else
      return int'((pc >> 2) % 64);
`endif
   endfunction

   function automatic int m_slot(input logic [31:0] pc);
      return int'((pc >> 2) % 16);
   endfunction

   function automatic bit m_taken(input logic [31:0] pc);
      int s;
      logic [31:0] stored;
      bit hit;
      s = m_slot(pc);
      stored = btb_pc[s];
      hit = btb_v[s] && (stored[31:2] == pc[31:2]);
      return hit && (btb_j[s] || (bht_m[m_idx(pc)] >= 2));
   endfunction

   function automatic logic [31:0] m_target(input logic [31:0] pc);
      return m_taken(pc) ? btb_tgt[m_slot(pc)] : pc + 32'd4;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) bht_m[i] = 1;
      for (int i = 0; i < 16; i++) btb_v[i] = 1'b0;
      ghr_m = 0;
      n_br  = 32'd0;
      n_mis = 32'd0;
   endtask

   task automatic idle();
      branchE      = 1'b0;
      jumpE        = 1'b0;
      branchTakenE = 1'b0;
   endtask

   // Drives an EX resolve; the "piped" prediction comes from the model's current view of PCE.
   task automatic drive_res(input bit br, input bit jp, input bit tk,
                            input logic [31:0] pce, input logic [31:0] tgt);
      branchE      = br;
      jumpE        = jp;
      branchTakenE = tk;
      PCE          = pce;
      PCPlus4E     = pce + 32'd4;
      PCTargetE    = tgt;
      predTakenE   = m_taken(pce);
      predTargetE  = m_target(pce);
      predIdxE     = 6'(m_idx(pce));
   endtask

   // Check all outputs against the model at the falling edge, then advance the model at the rising edge.
   task automatic cycle();
      bit res, tk, mis;
      int k;
      @(negedge clk);
      check_val("predTakenF", predTakenF, m_taken(PCF));
      check_val("predTargetF", predTargetF, m_target(PCF));
      check_val("predIdxF", predIdxF, m_idx(PCF));
      res = branchE | jumpE;
      tk  = jumpE | branchTakenE;
      mis = res && ((tk != predTakenE) || (tk && (predTargetE != PCTargetE)));
      check_val("mispredictE", mispredictE, mis);
      check_val("redirectPCE", redirectPCE, res ? (tk ? PCTargetE : PCPlus4E) : 32'd0);
      check_val("statBranches", statBranches, n_br);
      check_val("statMispred", statMispred, n_mis);
      @(posedge clk);
      if (!reset_n) begin
         model_reset();
      end else begin
         if (res) n_br = n_br + 32'd1;
         if (mis) n_mis = n_mis + 32'd1;
         if (branchE && !jumpE) begin
            k = int'(predIdxE);
            if (branchTakenE) bht_m[k] = (bht_m[k] == 3) ? 3 : bht_m[k] + 1;
            else              bht_m[k] = (bht_m[k] == 0) ? 0 : bht_m[k] - 1;
            ghr_m = ((ghr_m << 1) | int'(branchTakenE)) % 64;
         end
         if (res && tk) begin
            k = m_slot(PCE);
            btb_v[k]   = 1'b1;
            btb_j[k]   = jumpE;
            btb_pc[k]  = PCE;
            btb_tgt[k] = PCTargetE;
         end
      end
      #1;
   endtask

   logic [31:0] pool [8];

   initial begin
      pool = '{32'h100, 32'h140, 32'h200, 32'h240, 32'h1000, 32'h1040, 32'h3c, 32'h7c};
      reset_n = 1'b0;
      PCF = 32'h100;
      PCE = 32'd0; PCPlus4E = 32'd4; PCTargetE = 32'd0;
      predTakenE = 1'b0; predTargetE = 32'd0; predIdxE = 6'd0;
      idle();
      model_reset();
      @(posedge clk); #1;
      cycle();
      reset_n = 1'b1;

      // Reset state
      PCF = 32'h100; #2;
      check_val("rst_predTaken", predTakenF, 32'd0);
      check_val("rst_predTarget", predTargetF, 32'h104);
      check_val("rst_predIdx", predIdxF, 32'h0);
      check_val("rst_statBr", statBranches, 32'd0);
      cycle();

      // First taken branch mispredicts and trains
      drive_res(1'b1, 1'b0, 1'b1, 32'h100, 32'h80); #2;
      check_val("t2_mispred", mispredictE, 32'd1);
      check_val("t2_redirect", redirectPCE, 32'h80);
      cycle();
      idle(); PCF = 32'h100; #2;
`ifndef BP_GSHARE_EN
      check_val("t2_predTaken", predTakenF, 32'd1);
      check_val("t2_predTarget", predTargetF, 32'h80);
`endif
      cycle();

      // Not-taken run saturates the counter low
      for (int i = 0; i < 5; i++) begin
         drive_res(1'b1, 1'b0, 1'b0, 32'h100, 32'h80);
         cycle();
      end
      idle(); PCF = 32'h100; #2;
`ifndef BP_GSHARE_EN
      check_val("t3_predTaken", predTakenF, 32'd0);
      check_val("t3_predTarget", predTargetF, 32'h104);
`endif
      cycle();

      // Jump entry predicts taken regardless of BHT, then an alias evicts it
      drive_res(1'b0, 1'b1, 1'b0, 32'h200, 32'h400); cycle();
      idle(); PCF = 32'h200; #2;
      check_val("t4_jmpTaken", predTakenF, 32'd1);
      check_val("t4_jmpTarget", predTargetF, 32'h400);
      cycle();
      drive_res(1'b1, 1'b0, 1'b1, 32'h240, 32'h500); cycle();
      idle(); PCF = 32'h200; #2;
      check_val("t4_aliasTaken", predTakenF, 32'd0);
      check_val("t4_aliasTarget", predTargetF, 32'h204);
      cycle();

      // Same-cycle lookup and update of one entry: lookup sees the old contents
      PCF = 32'h240;
      drive_res(1'b0, 1'b1, 1'b0, 32'h240, 32'h600); #2;
`ifndef BP_GSHARE_EN
      check_val("t5_oldTarget", predTargetF, 32'h500);
`endif
      cycle();
      idle(); #2;
      check_val("t5_newTarget", predTargetF, 32'h600);
      cycle();

      // Reset during a resolve wins
      reset_n = 1'b0;
      drive_res(1'b1, 1'b0, 1'b1, 32'h300, 32'h700); cycle();
      reset_n = 1'b1; idle(); PCF = 32'h300; #2;
      check_val("t5_rstTaken", predTakenF, 32'd0);
      check_val("t5_rstTarget", predTargetF, 32'h304);
      check_val("t5_rstStatBr", statBranches, 32'd0);
      check_val("t5_rstStatMis", statMispred, 32'd0);
      cycle();
      PCF = 32'h240; #2;
      check_val("t5_rstBtb", predTargetF, 32'h244);
      cycle();

`ifdef BP_GSHARE_EN
      // History T,T,N lands in the low GHR bits
      drive_res(1'b1, 1'b0, 1'b1, 32'h1000, 32'h2000); cycle();
      drive_res(1'b1, 1'b0, 1'b1, 32'h1000, 32'h2000); cycle();
      drive_res(1'b1, 1'b0, 1'b0, 32'h1000, 32'h2000); cycle();
      idle(); PCF = 32'h100; #2;
      check_val("t6_gshareIdx", predIdxF, 32'h06);
      cycle();
`endif

      // Random traffic
      for (int n = 0; n < 1000; n++) begin
         int kind;
         logic [31:0] tgt;
         reset_n = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
         PCF  = pool[$urandom_range(0, 7)];
         tgt  = 32'($urandom_range(0, 1023)) << 2;
         kind = $urandom_range(0, 9);
         if (kind < 4)      idle();
         else if (kind < 8) drive_res(1'b1, 1'b0, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], tgt);
         else               drive_res(1'b0, 1'b1, 1'b0, pool[$urandom_range(0, 7)], tgt);
         case ($urandom_range(0, 7))
            0:       predTakenE = ~predTakenE;
            1:       predTargetE = predTargetE ^ 32'h10;
            default: ;
         endcase
         cycle();
      end
      reset_n = 1'b1; idle(); #2;
      check_val("final_statMispred", statMispred, n_mis);
      check_val("final_statBranches", statBranches, n_br);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
